traffic_light_top: RTL and testbench
====================================

Name: traffic_light_top

Overview:
- Two-road intersection traffic-light controller; top level of the traffic design.
- Drives a 3-bit lamp vector per road and a 6-bit countdown of the time remaining in the current phase.
- Cycles through four phases: road1 green, road1 yellow, road2 green, road2 yellow.
- Time base is a clock-enable "tick" from an internal prescaler; one tick equals one display unit.

Parameters:
- GREEN_TIME, 30, ticks spent in each green phase (legal range 1..63).
- YELLOW_TIME, 5, ticks spent in each yellow phase (legal range 1..63).
- TICK_DIV, 1, clock cycles per tick (legal range 1..2^16); 1 means every clock is a tick.

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst_n  input  1  reset; asynchronous, active-high despite the name (1 = reset asserted).
- light1  output  3  road1 lamps, one-hot {red, yellow, green} = bits [2],[1],[0].
- light2  output  3  road2 lamps, same encoding as light1.
- count  output  6  ticks remaining in the current phase, unsigned.

Behaviour:
- All outputs are registered.
- Lamp codes: red 3'b100, yellow 3'b010, green 3'b001. Each lamp vector is always exactly one-hot.
- Reset (rst_n=1, asynchronous):
  - state=S0, prescaler=0, count=GREEN_TIME.
  - light1=3'b001, light2=3'b100.
  - Outputs hold these values for as long as reset is high.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - tick=1 on the cycle the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
  - With TICK_DIV=1, tick is permanently 1 outside reset.
- States (light1 / light2 / phase length):
  - S0: green / red / GREEN_TIME
  - S1: yellow / red / YELLOW_TIME
  - S2: red / green / GREEN_TIME
  - S3: red / yellow / YELLOW_TIME
  - S3 is followed by S0.
- On each tick:
  - count>1: count decrements by 1 and the state holds.
  - count==1: the state advances, count loads the next phase length, and the lights update on the same clock edge.
- Phase timing: each phase shows count values from its length down to 1. S0 therefore lasts exactly GREEN_TIME ticks.
- Full cycle: 2*(GREEN_TIME+YELLOW_TIME) ticks, 70 with defaults.
- Between ticks, all registers except the prescaler hold.
- count is never 0 in operation and never wraps.
- Safety: the two roads are never both non-red. Any illegal state encoding recovers to the S0 values on the next clock.
- Reset mid-phase: returns immediately to the reset values. After release, S0 restarts with the full GREEN_TIME.
- Reset release: the first tick occurs TICK_DIV clock edges after release.

Test Plan:
- Hold rst_n=1 for 3 cycles -> light1=001, light2=100, count=30 on every cycle, including before the first clock edge.
- Defaults; release reset, run 30 clocks -> count 30→1 with light1=001 throughout. Edge 30 -> light1=010, light2=100, count=5.
- Run a full 70-clock cycle -> phase order S0(30) S1(5) S2(30) S3(5), then back to light1=001, light2=100, count=30. Lamps one-hot every cycle; light1 and light2 never both non-red.
- Pulse rst_n=1 asynchronously mid-S2 (light2=001, count=12) -> outputs return to 001/100/30 without waiting for a clock edge. After release, S0 lasts the full 30 clocks.
- GREEN_TIME=3, YELLOW_TIME=2, TICK_DIV=4 -> count changes only every 4th clock; sequence 3,2,1 (S0), 2,1 (S1), 3,2,1 (S2), 2,1 (S3), 3 (S0); each value held for 4 clocks.
- GREEN_TIME=1, YELLOW_TIME=1, TICK_DIV=1 -> state advances on every clock, count constantly 1, lights rotate S0→S1→S2→S3→S0.

Source files
------------

// File: rtl/traffic_light_top.sv
// Two-road intersection traffic-light controller.
// A prescaler produces a one-cycle tick every TICK_DIV clocks. Each tick
// either decrements the phase countdown or, on the last unit of the phase,
// advances to the next phase and reloads the countdown.
module traffic_light_top #(
    parameter int GREEN_TIME  = 30,
    parameter int YELLOW_TIME = 5,
    parameter int TICK_DIV    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] light1,
    output logic [2:0] light2,
    output logic [5:0] count
);

    // Prescaler width covers 0..TICK_DIV-1; at least one bit so that
    // TICK_DIV=1 still elaborates (the prescaler then sits at zero).
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    localparam logic [5:0] GREEN_CNT  = 6'(GREEN_TIME);
    localparam logic [5:0] YELLOW_CNT = 6'(YELLOW_TIME);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;
    localparam logic [1:0] S3 = 2'd3;

    logic [PW-1:0] prescaler;
    logic          tick;
    logic [1:0]    state;

    logic [1:0]    next_state;
    logic [5:0]    next_len;
    logic [2:0]    next_light1;
    logic [2:0]    next_light2;

    assign tick = (prescaler == PRE_MAX);

    // Prescaler free-runs 0..TICK_DIV-1 and wraps on the tick cycle.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Phase that follows the current one, with its length and lamp codes;
    // any unexpected encoding falls back to the S0 values.
    always_comb begin
        next_state  = S0;
        next_len    = GREEN_CNT;
        next_light1 = LAMP_GREEN;
        next_light2 = LAMP_RED;
        case (state)
            S0: begin
                next_state  = S1;
                next_len    = YELLOW_CNT;
                next_light1 = LAMP_YELLOW;
                next_light2 = LAMP_RED;
            end
            S1: begin
                next_state  = S2;
                next_len    = GREEN_CNT;
                next_light1 = LAMP_RED;
                next_light2 = LAMP_GREEN;
            end
            S2: begin
                next_state  = S3;
                next_len    = YELLOW_CNT;
                next_light1 = LAMP_RED;
                next_light2 = LAMP_YELLOW;
            end
            S3: begin
                next_state  = S0;
                next_len    = GREEN_CNT;
                next_light1 = LAMP_GREEN;
                next_light2 = LAMP_RED;
            end
            default: begin
                next_state  = S0;
                next_len    = GREEN_CNT;
                next_light1 = LAMP_GREEN;
                next_light2 = LAMP_RED;
            end
        endcase
    end

    // Phase register, countdown and lamp outputs update only on ticks.
    // A count of 1 (or an impossible 0) ends the phase so count never wraps.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state  <= S0;
            count  <= GREEN_CNT;
            light1 <= LAMP_GREEN;
            light2 <= LAMP_RED;
        end else if (tick) begin
            if (count > 6'd1) begin
                count <= count - 6'd1;
            end else begin
                state  <= next_state;
                count  <= next_len;
                light1 <= next_light1;
                light2 <= next_light2;
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_top.sv
// Testbench for traffic_light_top: three parameterisations run side by side
// from one clock and reset, checked every cycle against an arithmetic model
// of phase position derived from elapsed ticks since reset release.
module tb_traffic_light_top;

    logic clk;
    logic rst;

    logic [2:0] def_l1, def_l2;
    logic [5:0] def_cnt;
    logic [2:0] slow_l1, slow_l2;
    logic [5:0] slow_cnt;
    logic [2:0] fast_l1, fast_l2;
    logic [5:0] fast_cnt;

    int compared;
    int mismatched;
    int edges;

    traffic_light_top dut_def (
        .clk    (clk),
        .rst_n  (rst),
        .light1 (def_l1),
        .light2 (def_l2),
        .count  (def_cnt)
    );

    traffic_light_top #(
        .GREEN_TIME  (3),
        .YELLOW_TIME (2),
        .TICK_DIV    (4)
    ) dut_slow (
        .clk    (clk),
        .rst_n  (rst),
        .light1 (slow_l1),
        .light2 (slow_l2),
        .count  (slow_cnt)
    );

    traffic_light_top #(
        .GREEN_TIME  (1),
        .YELLOW_TIME (1),
        .TICK_DIV    (1)
    ) dut_fast (
        .clk    (clk),
        .rst_n  (rst),
        .light1 (fast_l1),
        .light2 (fast_l2),
        .count  (fast_cnt)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs from elapsed clock edges since release: ticks are
    // edges/div, and the position inside the 2*(g+y) cycle picks the phase.
    function automatic void modelExp(input int g, input int y, input int d,
                                     input int e, input bit in_reset,
                                     output logic [2:0] l1,
                                     output logic [2:0] l2,
                                     output logic [5:0] c);
        int p;
        if (in_reset) begin
            l1 = 3'b001; l2 = 3'b100; c = 6'(g);
            return;
        end
        p = (e / d) % (2 * (g + y));
        if (p < g) begin
            l1 = 3'b001; l2 = 3'b100; c = 6'(g - p);
        end else if (p < g + y) begin
            l1 = 3'b010; l2 = 3'b100; c = 6'(g + y - p);
        end else if (p < 2 * g + y) begin
            l1 = 3'b100; l2 = 3'b001; c = 6'(2 * g + y - p);
        end else begin
            l1 = 3'b100; l2 = 3'b010; c = 6'(2 * g + 2 * y - p);
        end
    endfunction

    // Compare one instance against the model plus lamp sanity rules.
    task automatic checkOutput(input string tag, input int g, input int y,
                               input int d, input logic [2:0] l1,
                               input logic [2:0] l2, input logic [5:0] c);
        logic [2:0] exp_l1, exp_l2;
        logic [5:0] exp_c;
        logic       safe;
        modelExp(g, y, d, edges, rst, exp_l1, exp_l2, exp_c);
        compared++;
        assert (l1 === exp_l1) else begin
            mismatched++;
            $error("[TB] FAIL %s.light1 e=%0d observed=%b expected=%b", tag, edges, l1, exp_l1);
        end
        compared++;
        assert (l2 === exp_l2) else begin
            mismatched++;
            $error("[TB] FAIL %s.light2 e=%0d observed=%b expected=%b", tag, edges, l2, exp_l2);
        end
        compared++;
        assert (c === exp_c) else begin
            mismatched++;
            $error("[TB] FAIL %s.count e=%0d observed=%0d expected=%0d", tag, edges, c, exp_c);
        end
        compared++;
        assert (($onehot(l1) && $onehot(l2)) === 1'b1) else begin
            mismatched++;
            $error("[TB] FAIL %s.onehot observed=%b/%b expected=onehot", tag, l1, l2);
        end
        safe = (l1 === 3'b100) || (l2 === 3'b100);
        compared++;
        assert (safe === 1'b1) else begin
            mismatched++;
            $error("[TB] FAIL %s.safety observed=%b/%b expected=one red", tag, l1, l2);
        end
    endtask

    task automatic checkAll();
        checkOutput("def",  30, 5, 1, def_l1,  def_l2,  def_cnt);
        checkOutput("slow",  3, 2, 4, slow_l1, slow_l2, slow_cnt);
        checkOutput("fast",  1, 1, 1, fast_l1, fast_l2, fast_cnt);
    endtask

    // Advance n clocks, checking all instances 1 time unit after each edge.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (!rst) edges++;
            #1;
            checkAll();
        end
    endtask

    // Assert reset between clock edges, check it takes effect without a
    // clock, hold it across an edge, then release on a falling edge.
    task automatic pulseReset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkAll();
        applyStimulus(1);
        @(negedge clk);
        rst   = 1'b0;
        edges = 0;
    endtask

    initial begin
        int run_len;
        compared   = 0;
        mismatched = 0;
        edges      = 0;
        rst        = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        $display("[TB] reset asserted, checking before first clock edge");
        checkAll();
        applyStimulus(3);

        @(negedge clk);
        rst   = 1'b0;
        edges = 0;
        $display("[TB] reset released, running full cycle and into S2");
        applyStimulus(123);
        pulseReset();

        $display("[TB] checking full green phase after mid-phase reset");
        applyStimulus(35);

        for (int k = 0; k < 4; k++) begin
            run_len = int'($urandom_range(1, 90));
            applyStimulus(run_len);
            pulseReset();
        end
        applyStimulus(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
